// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and default address map for the MEM-side bus sequencer.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [1:0] {RGN_RAM1, RGN_UART, RGN_UNMAP} region_t;

  typedef struct packed {
    logic is_ram1;
    logic is_uart;
    logic rd;
    logic wr;
  } bus_ctrl_t;

  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;
  localparam logic [15:0] UNMAP_LO_DEF       = 16'hBF02;
  localparam logic [15:0] UNMAP_HI           = 16'hBFFF;
  localparam int          CNT_W              = 4;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// MEM-stage request side and RAM1/UART port-block side of the bus sequencer.
interface mem_bus_ctrl_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic [15:0] ram1res_i;
  logic        is_RAM1_o;
  logic        is_UART_o;
  logic [17:0] addr_o;
  logic [15:0] data_o;
  logic        isread_o;
  logic        iswrite_o;
  logic [15:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        proto_err_o;

  // master: the sequencer itself; slave: the CPU pipeline plus port block
  modport master (
    input  mem_read_i, mem_write_i, mem_addr_i, mem_wdata_i, ram1res_i,
    output is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o,
           rdata_o, stall_o, done_o, proto_err_o
  );

  modport slave (
    output mem_read_i, mem_write_i, mem_addr_i, mem_wdata_i, ram1res_i,
    input  is_RAM1_o, is_UART_o, addr_o, data_o, isread_o, iswrite_o,
           rdata_o, stall_o, done_o, proto_err_o
  );
endinterface

// File: rtl/mem_bus_ctrl_decode.sv
// Combinational address-to-region decoder; also meant for the fetch side.
module mem_addr_decode
  import mem_bus_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter logic [15:0] UNMAP_LO       = UNMAP_LO_DEF
) (
  input  logic [15:0] addr,
  output region_t     rgn
);

  always_comb begin
    rgn = RGN_RAM1;
    if (addr == UART_DATA_ADDR || addr == UART_STAT_ADDR)
      rgn = RGN_UART;
    else if (addr >= UNMAP_LO && addr <= UNMAP_HI)
      rgn = RGN_UNMAP;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences one MEM-stage load/store onto the RAM1/UART port block,
// holding registered bus controls for ACCESS_CYCLES and stalling meanwhile.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES  = 1,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter logic [15:0] UNMAP_LO       = UNMAP_LO_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_bus_ctrl_if.master bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        addr_q, wdata_q, rdata_q;
  bus_ctrl_t          ctrl_q;
  region_t            rgn;
  logic               req, is_wr, last;

  mem_addr_decode #(
    .UART_DATA_ADDR (UART_DATA_ADDR),
    .UART_STAT_ADDR (UART_STAT_ADDR),
    .UNMAP_LO       (UNMAP_LO)
  ) u_dec (
    .addr (bus.mem_addr_i),
    .rgn  (rgn)
  );

  assign req   = bus.mem_read_i | bus.mem_write_i;
  assign is_wr = bus.mem_write_i;  // read+write together resolves to a write
  assign last  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = (rgn == RGN_UNMAP) ? DONE : ACCESS;
      ACCESS:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (req) begin
          addr_q  <= bus.mem_addr_i;
          wdata_q <= bus.mem_wdata_i;
          cnt_q   <= CNT_W'(ACCESS_CYCLES - 1);
          if (rgn == RGN_UNMAP) begin
            // unmapped: loads return zero, stores vanish
            if (!is_wr) rdata_q <= '0;
            ctrl_q <= '0;
          end else begin
            ctrl_q <= '{is_ram1: (rgn == RGN_RAM1), is_uart: (rgn == RGN_UART),
                        rd: !is_wr, wr: is_wr};
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 1'b1;
          if (last) begin
            if (ctrl_q.rd) rdata_q <= bus.ram1res_i;
            ctrl_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.is_RAM1_o   = ctrl_q.is_ram1;
  assign bus.is_UART_o   = ctrl_q.is_uart;
  assign bus.isread_o    = ctrl_q.rd;
  assign bus.iswrite_o   = ctrl_q.wr;
  assign bus.addr_o      = {2'b00, addr_q};
  assign bus.data_o      = wdata_q;
  assign bus.rdata_o     = rdata_q;
  // combinational in the request cycle so the pipeline freezes immediately
  assign bus.stall_o     = ((state_q == IDLE) && req && !rst) || (state_q == ACCESS);
  assign bus.done_o      = (state_q == DONE);
  assign bus.proto_err_o = (state_q == IDLE) && bus.mem_read_i && bus.mem_write_i && !rst;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Drives two sequencers (ACCESS_CYCLES 1 and 3) from a vector table and checks
// per-cycle strobes plus a read-data scoreboard popped on done_o.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_d, rd_d, wr_d;
  logic [1:0][15:0] addr_d, wdata_d, res_d;
  logic [1:0]       o_ram1, o_uart, o_rd, o_wr, o_stall, o_done, o_err;
  logic [1:0][17:0] o_addr;
  logic [1:0][15:0] o_data, o_rdata;

  mem_bus_ctrl_if bus1();
  mem_bus_ctrl_if bus3();

  assign bus1.mem_read_i  = rd_d[0];
  assign bus1.mem_write_i = wr_d[0];
  assign bus1.mem_addr_i  = addr_d[0];
  assign bus1.mem_wdata_i = wdata_d[0];
  assign bus1.ram1res_i   = res_d[0];
  assign bus3.mem_read_i  = rd_d[1];
  assign bus3.mem_write_i = wr_d[1];
  assign bus3.mem_addr_i  = addr_d[1];
  assign bus3.mem_wdata_i = wdata_d[1];
  assign bus3.ram1res_i   = res_d[1];

  assign o_ram1  = {bus3.is_RAM1_o,   bus1.is_RAM1_o};
  assign o_uart  = {bus3.is_UART_o,   bus1.is_UART_o};
  assign o_rd    = {bus3.isread_o,    bus1.isread_o};
  assign o_wr    = {bus3.iswrite_o,   bus1.iswrite_o};
  assign o_stall = {bus3.stall_o,     bus1.stall_o};
  assign o_done  = {bus3.done_o,      bus1.done_o};
  assign o_err   = {bus3.proto_err_o, bus1.proto_err_o};
  assign o_addr  = {bus3.addr_o,      bus1.addr_o};
  assign o_data  = {bus3.data_o,      bus1.data_o};
  assign o_rdata = {bus3.rdata_o,     bus1.rdata_o};

  mem_bus_ctrl #(.ACCESS_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst_d[0]), .bus(bus1));
  mem_bus_ctrl #(.ACCESS_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst_d[1]), .bus(bus3));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] res;
    region_t     rgn;
  } vec_t;

  vec_t        vt[11];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] hold[2];
  logic [15:0] sbq0[$];
  logic [15:0] sbq1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [15:0] v);
    if (k == 0) sbq0.push_back(v); else sbq1.push_back(v);
  endtask

  task automatic sb_check(input int k, input string p);
    logic [15:0] v;
    bit ok;
    ok = 1'b1;
    v  = '0;
    if (k == 0) begin
      if (sbq0.size() == 0) ok = 1'b0; else v = sbq0.pop_front();
    end else begin
      if (sbq1.size() == 0) ok = 1'b0; else v = sbq1.pop_front();
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s rdata: done_o with no expected completion", p);
    end else
      chk({p, " rdata"}, o_rdata[k], v);
  endtask

  task automatic chk_idle(input int k, input string p);
    chk({p, " stall"}, o_stall[k], 0);
    chk({p, " done"},  o_done[k],  0);
    chk({p, " err"},   o_err[k],   0);
    chk({p, " sel"},   {o_ram1[k], o_uart[k]}, 0);
    chk({p, " strb"},  {o_rd[k], o_wr[k]},     0);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int  ac[2];
    int  dc[2];
    bit  mapped, act;
    string p;
    ac[0] = 1; ac[1] = 3;
    mapped = (t.rgn != RGN_UNMAP);
    for (int k = 0; k < 2; k++) begin
      dc[k] = mapped ? ac[k] + 1 : 1;
      if (t.rd && !t.wr) hold[k] = mapped ? t.res : 16'h0000;
      sb_push(k, hold[k]);
    end
    for (int c = 0; c <= dc[1]; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rd_d[k]    = (c <= dc[k]) ? t.rd : 1'b0;
        wr_d[k]    = (c <= dc[k]) ? t.wr : 1'b0;
        addr_d[k]  = t.addr;
        wdata_d[k] = t.wdata;
        res_d[k]   = (c == ac[k]) ? t.res : ~t.res;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        p   = $sformatf("v%0d i%0d c%0d", idx, k, c);
        act = mapped && c >= 1 && c <= ac[k];
        chk({p, " stall"}, o_stall[k], c < dc[k]);
        chk({p, " done"},  o_done[k],  c == dc[k]);
        chk({p, " err"},   o_err[k],   c == 0 && t.rd && t.wr);
        chk({p, " ram1"},  o_ram1[k],  act && t.rgn == RGN_RAM1);
        chk({p, " uart"},  o_uart[k],  act && t.rgn == RGN_UART);
        chk({p, " isread"},  o_rd[k],  act && t.rd && !t.wr);
        chk({p, " iswrite"}, o_wr[k],  act && t.wr);
        if (act) chk({p, " addr"}, o_addr[k], {2'b00, t.addr});
        if (act && t.wr) chk({p, " data"}, o_data[k], t.wdata);
        if (o_done[k]) sb_check(k, p);
      end
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'h1234, RGN_RAM1};
    vt[1]  = '{1'b0, 1'b1, 16'hBF00, 16'hBEEF, 16'h0000, RGN_UART};
    vt[2]  = '{1'b1, 1'b0, 16'hBF10, 16'h0000, 16'h4321, RGN_UNMAP};
    vt[3]  = '{1'b1, 1'b1, 16'h9000, 16'h0055, 16'h6666, RGN_RAM1};
    vt[4]  = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h00A5, RGN_UART};
    vt[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, RGN_RAM1};
    vt[6]  = '{1'b0, 1'b1, 16'hBFFF, 16'h1111, 16'h0000, RGN_UNMAP};
    vt[7]  = '{1'b1, 1'b0, 16'hBF02, 16'h0000, 16'h2222, RGN_UNMAP};
    vt[8]  = '{1'b1, 1'b0, 16'hBEFF, 16'h0000, 16'h7777, RGN_RAM1};
    vt[9]  = '{1'b0, 1'b1, 16'hC000, 16'hA5A5, 16'h0000, RGN_RAM1};
    vt[10] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, RGN_RAM1};

    rst_d = 2'b11; rd_d = '0; wr_d = '0; addr_d = '0; wdata_d = '0; res_d = '0;
    hold[0] = '0; hold[1] = '0;
    repeat (2) @(negedge clk);
    rst_d = 2'b00;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_idle(k, $sformatf("reset i%0d", k));
      chk($sformatf("reset i%0d rdata", k), o_rdata[k], 0);
    end

    // back-to-back: each request is held through its DONE cycle
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // reset in the second ACCESS cycle of a 3-cycle read aborts it
    @(negedge clk);
    rd_d[1] = 1'b1; wr_d[1] = 1'b0; addr_d[1] = 16'h8010; res_d[1] = 16'h5A5A;
    #1 chk("rst_seq c0 stall", o_stall[1], 1);
    @(negedge clk);
    #1 chk("rst_seq c1 isread", o_rd[1], 1);
    @(negedge clk);
    rst_d[1] = 1'b1;
    #1 chk("rst_seq c2 done", o_done[1], 0);
    @(negedge clk);
    rst_d[1] = 1'b0; rd_d[1] = 1'b0;
    #1;
    chk_idle(1, "rst_seq c3");
    chk("rst_seq c3 rdata", o_rdata[1], 0);
    chk("rst_seq c3 addr",  o_addr[1],  0);
    @(negedge clk);
    #1 chk("rst_seq c4 done", o_done[1], 0);
    chk("rst_seq c4 i0 done", o_done[0], 0);

    chk("sb0 drained", sbq0.size(), 0);
    chk("sb1 drained", sbq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
